// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, colour type and fetch FSM states
// for the screen reader.
package vga_pkg;

  localparam int unsigned CntW = 10;

  localparam logic [CntW-1:0] HVisible   = 10'd640;
  localparam logic [CntW-1:0] HFront     = 10'd16;
  localparam logic [CntW-1:0] HSync      = 10'd96;
  localparam logic [CntW-1:0] HBack      = 10'd48;
  localparam logic [CntW-1:0] HTotal     = HVisible + HFront + HSync + HBack;
  localparam logic [CntW-1:0] HSyncStart = HVisible + HFront;
  localparam logic [CntW-1:0] HSyncEnd   = HSyncStart + HSync;

  localparam logic [CntW-1:0] VVisible   = 10'd480;
  localparam logic [CntW-1:0] VFront     = 10'd10;
  localparam logic [CntW-1:0] VSync      = 10'd2;
  localparam logic [CntW-1:0] VBack      = 10'd33;
  localparam logic [CntW-1:0] VTotal     = VVisible + VFront + VSync + VBack;
  localparam logic [CntW-1:0] VSyncStart = VVisible + VFront;
  localparam logic [CntW-1:0] VSyncEnd   = VSyncStart + VSync;

  typedef logic [11:0] rgb444_t;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StCapture
  } fetch_state_e;

endpackage

// File: rtl/vga_timing.sv
// Pixel-tick generator and 800x525 raster counters with raw (undelayed)
// active-low syncs, visible-area flag and vblank.
module vga_timing
  import vga_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            tick_o,
  output logic [CntW-1:0] h_cnt_o,
  output logic [CntW-1:0] v_cnt_o,
  output logic            visible_o,
  output logic            hs_raw_o,
  output logic            vs_raw_o,
  output logic            vblank_o
);

  logic            phase_q, phase_d;
  logic [CntW-1:0] h_q, h_d;
  logic [CntW-1:0] v_q, v_d;

  always_comb begin
    phase_d = ~phase_q;
    h_d     = h_q;
    v_d     = v_q;
    if (phase_q) begin
      if (h_q == HTotal - 10'd1) begin
        h_d = '0;
        v_d = (v_q == VTotal - 10'd1) ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  assign tick_o    = phase_q;
  assign h_cnt_o   = h_q;
  assign v_cnt_o   = v_q;
  assign visible_o = (h_q < HVisible) && (v_q < VVisible);
  assign hs_raw_o  = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
  assign vs_raw_o  = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
  assign vblank_o  = (v_q >= VVisible);

endmodule

// File: rtl/vga_screen_reader.sv
// Framebuffer scan-out: fetches 1-bpp words from the screen RAM port and
// serialises them to VGA with PIXEL_SCALE magnification. Optional macro
// VGA_TEST_PATTERN_EN adds a checkerboard override input (test_pattern).
module vga_screen_reader
  import vga_pkg::*;
#(
  parameter int unsigned WIDTH          = 16,
  parameter int unsigned REGISTER_COUNT = 4096,
  parameter int unsigned PIXEL_SCALE    = 4,
  parameter rgb444_t     FG_COLOR       = 12'hFFF,
  parameter rgb444_t     BG_COLOR       = 12'h000
) (
  input  logic                              CLK_50,
  input  logic                              rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                              test_pattern,
`endif
  input  logic [WIDTH-1:0]                  rdata_screen,
  output logic [$clog2(REGISTER_COUNT)-1:0] addr_screen,
  output logic [3:0]                        vga_r,
  output logic [3:0]                        vga_g,
  output logic [3:0]                        vga_b,
  output logic                              vga_hs,
  output logic                              vga_vs,
  output logic                              vblank
);

  localparam int unsigned AddrW        = $clog2(REGISTER_COUNT);
  localparam int unsigned WordPix      = WIDTH * PIXEL_SCALE;
  localparam int unsigned WordsPerLine = 640 / WordPix;
  localparam int unsigned PsLog2       = $clog2(PIXEL_SCALE);
  localparam int unsigned WordLog2     = $clog2(WordPix);
  localparam logic [CntW-1:0] PsMask   = CntW'(PIXEL_SCALE - 1);
  localparam logic [CntW-1:0] WordMask = CntW'(WordPix - 1);

  logic            tick;
  logic [CntW-1:0] h_cnt, v_cnt;
  logic            visible, hs_raw, vs_raw;

  vga_timing u_timing (
    .clk_i     (CLK_50),
    .rst_i     (rst),
    .tick_o    (tick),
    .h_cnt_o   (h_cnt),
    .v_cnt_o   (v_cnt),
    .visible_o (visible),
    .hs_raw_o  (hs_raw),
    .vs_raw_o  (vs_raw),
    .vblank_o  (vblank)
  );

  fetch_state_e     fsm_q, fsm_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]  h_p1_q, h_p1_d;
  logic             vis_p1_q, vis_p1_d;
  logic             hs_p1_q, hs_p1_d;
  logic             vs_p1_q, vs_p1_d;
  rgb444_t          rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
`ifdef VGA_TEST_PATTERN_EN
  logic [CntW-1:0]  v_p1_q, v_p1_d;
`endif

  logic             fetch_start;
  logic [AddrW-1:0] next_addr;
  logic [WIDTH-1:0] base;
  rgb444_t          color;

  assign fetch_start = tick && visible && ((h_cnt & WordMask) == '0);
  assign next_addr   = AddrW'(((32'(v_cnt) >> PsLog2) * WordsPerLine)
                              + (32'(h_cnt) >> WordLog2));

  always_comb begin
    fsm_d    = fsm_q;
    addr_d   = addr_q;
    hold_d   = hold_q;
    shift_d  = shift_q;
    h_p1_d   = h_p1_q;
    vis_p1_d = vis_p1_q;
    hs_p1_d  = hs_p1_q;
    vs_p1_d  = vs_p1_q;
    rgb_d    = rgb_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
`ifdef VGA_TEST_PATTERN_EN
    v_p1_d   = v_p1_q;
`endif

    unique case (fsm_q)
      StIdle: begin
        if (fetch_start) begin
          fsm_d  = StAddr;
          addr_d = next_addr;
        end
      end
      StAddr:    fsm_d = StCapture;
      StCapture: begin
        fsm_d  = StIdle;
        hold_d = rdata_screen;
      end
      default:   fsm_d = StIdle;
    endcase

    // Capture lands on the tick that renders the word's first pixel, so the
    // freshly captured word bypasses the shift register for that tick.
    base  = (fsm_q == StCapture) ? hold_d : shift_q;
    color = base[WIDTH-1] ? FG_COLOR : BG_COLOR;
`ifdef VGA_TEST_PATTERN_EN
    if (test_pattern) begin
      color = (h_p1_q[PsLog2] ^ v_p1_q[PsLog2]) ? FG_COLOR : BG_COLOR;
    end
`endif

    if (tick) begin
      shift_d  = ((h_p1_q & PsMask) == PsMask) ? {base[WIDTH-2:0], 1'b0} : base;
      rgb_d    = vis_p1_q ? color : '0;
      hs_d     = hs_p1_q;
      vs_d     = vs_p1_q;
      h_p1_d   = h_cnt;
      vis_p1_d = visible;
      hs_p1_d  = hs_raw;
      vs_p1_d  = vs_raw;
`ifdef VGA_TEST_PATTERN_EN
      v_p1_d   = v_cnt;
`endif
    end
  end

  always_ff @(posedge CLK_50) begin
    if (rst) begin
      fsm_q    <= StIdle;
      addr_q   <= '0;
      hold_q   <= '0;
      shift_q  <= '0;
      h_p1_q   <= '0;
      vis_p1_q <= 1'b0;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
      rgb_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
`ifdef VGA_TEST_PATTERN_EN
      v_p1_q   <= '0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      addr_q   <= addr_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      h_p1_q   <= h_p1_d;
      vis_p1_q <= vis_p1_d;
      hs_p1_q  <= hs_p1_d;
      vs_p1_q  <= vs_p1_d;
      rgb_q    <= rgb_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
`ifdef VGA_TEST_PATTERN_EN
      v_p1_q   <= v_p1_d;
`endif
    end
  end

  assign addr_screen = addr_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;

endmodule

// File: tb/tb_vga_screen_reader.sv
// Bench for vga_screen_reader: random framebuffer contents, a raster-level
// reference model, and directed reset / blanking / word-boundary scenarios.
module tb_vga_screen_reader;

  localparam logic [11:0] Fg = 12'hFFF;
  localparam logic [11:0] Bg = 12'h000;

  logic        CLK_50 = 1'b0;
  logic        rst    = 1'b1;
  logic [15:0] rdata_screen;
  logic [11:0] addr_screen;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, vblank;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_pattern = 1'b0;
`endif

  vga_screen_reader dut (
    .CLK_50       (CLK_50),
    .rst          (rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_pattern (test_pattern),
`endif
    .rdata_screen (rdata_screen),
    .addr_screen  (addr_screen),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vblank       (vblank)
  );

  always #10 CLK_50 = ~CLK_50;

  logic [15:0] mem [4096];
  always @(posedge CLK_50) rdata_screen <= mem[addr_screen];

  int          checks = 0;
  int          errors = 0;
  int unsigned tick_k;
  logic [11:0] last_addr;
  logic        prev_hs;
  int          fall_cnt;
  int unsigned fall0, fall1;
  logic        tp_mode = 1'b0;

  function automatic int unsigned h_of(input int unsigned k);
    return k % 800;
  endfunction

  function automatic int unsigned v_of(input int unsigned k);
    return (k / 800) % 525;
  endfunction

  // Output seen on tick k belongs to the raster position of tick k-2.
  function automatic logic [11:0] exp_rgb(input int unsigned k);
    int unsigned h, v;
    logic [15:0] w;
    if (k < 2) return 12'h000;
    h = h_of(k - 2);
    v = v_of(k - 2);
    if (h >= 640 || v >= 480) return 12'h000;
    if (tp_mode) return ((((h >> 2) ^ (v >> 2)) & 1) != 0) ? Fg : Bg;
    w = mem[(v / 4) * 10 + h / 64];
    return w[15 - (h % 64) / 4] ? Fg : Bg;
  endfunction

  function automatic logic exp_hs(input int unsigned k);
    int unsigned h;
    if (k < 2) return 1'b1;
    h = h_of(k - 2);
    return !(h >= 656 && h < 752);
  endfunction

  function automatic logic exp_vs(input int unsigned k);
    int unsigned v;
    if (k < 2) return 1'b1;
    v = v_of(k - 2);
    return !(v >= 490 && v < 492);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
  endtask

  // Entered and left on the falling edge of a non-tick cycle.
  task automatic do_reset();
    @(negedge CLK_50);
    rst = 1'b1;
    @(posedge CLK_50);
    @(negedge CLK_50);
    rst = 1'b0;
    checks++;
    if ({vga_r, vga_g, vga_b} !== 12'h000) begin
      errors++; $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b});
    end
    checks++;
    if (vga_hs !== 1'b1 || vga_vs !== 1'b1) begin
      errors++; $display("FAIL reset_sync got hs=%b vs=%b want 1 1", vga_hs, vga_vs);
    end
    checks++;
    if (vblank !== 1'b0) begin
      errors++; $display("FAIL reset_vblank got %b want 0", vblank);
    end
    checks++;
    if (addr_screen !== 12'd0) begin
      errors++; $display("FAIL reset_addr got %0d want 0", addr_screen);
    end
    tick_k    = 0;
    last_addr = 12'd0;
    prev_hs   = 1'b1;
    fall_cnt  = 0;
  endtask

  task automatic scan_and_check(input int unsigned n);
    logic [11:0] got;
    int unsigned h, v;
    for (int i = 0; i < int'(n); i++) begin
      @(negedge CLK_50);
      got = {vga_r, vga_g, vga_b};
      checks++;
      if (got !== exp_rgb(tick_k)) begin
        errors++; $display("FAIL rgb tick %0d got %h want %h", tick_k, got, exp_rgb(tick_k));
      end
      checks++;
      if (vga_hs !== exp_hs(tick_k)) begin
        errors++; $display("FAIL hs tick %0d got %b want %b", tick_k, vga_hs, exp_hs(tick_k));
      end
      checks++;
      if (vga_vs !== exp_vs(tick_k)) begin
        errors++; $display("FAIL vs tick %0d got %b want %b", tick_k, vga_vs, exp_vs(tick_k));
      end
      checks++;
      if (vblank !== (v_of(tick_k) >= 480)) begin
        errors++; $display("FAIL vblank tick %0d got %b", tick_k, vblank);
      end
      checks++;
      if (addr_screen !== last_addr) begin
        errors++; $display("FAIL addr tick %0d got %0d want %0d", tick_k, addr_screen, last_addr);
      end
      h = h_of(tick_k);
      v = v_of(tick_k);
      if (h < 640 && v < 480 && h % 64 == 0) last_addr = 12'((v / 4) * 10 + h / 64);
      if (prev_hs === 1'b1 && vga_hs === 1'b0) begin
        if (fall_cnt == 0) fall0 = tick_k;
        else if (fall_cnt == 1) fall1 = tick_k;
        fall_cnt++;
      end
      prev_hs = vga_hs;
      tick_k++;
      @(negedge CLK_50);
    end
  endtask

  task automatic test_reset();
    fill_random();
    do_reset();
    scan_and_check(10);
  endtask

  task automatic test_scan_random();
    fill_random();
    do_reset();
    scan_and_check(12 * 800);
    checks++;
    if (fall_cnt < 2 || fall0 != 658) begin
      errors++; $display("FAIL hs_first_fall got tick %0d (falls %0d) want 658", fall0, fall_cnt);
    end
    checks++;
    if (fall_cnt < 2 || (fall1 - fall0) * 2 != 1600) begin
      errors++; $display("FAIL line_period got %0d cycles want 1600", (fall1 - fall0) * 2);
    end
  endtask

  task automatic test_word0_blanking();
    logic [11:0] want;
    for (int i = 0; i < 4096; i++) mem[i] = 16'hFFFF;
    mem[0] = 16'h8000;
    do_reset();
    for (int k = 0; k < 70; k++) begin
      @(negedge CLK_50);
      if (k < 2) want = 12'h000;
      else if (k <= 5) want = Fg;
      else if (k <= 65) want = Bg;
      else want = Fg;
      checks++;
      if ({vga_r, vga_g, vga_b} !== want) begin
        errors++; $display("FAIL word0_pixel tick %0d got %h want %h", k, {vga_r, vga_g, vga_b}, want);
      end
      @(negedge CLK_50);
    end
    // Rest of line 0 plus line 1 with an all-ones RAM: blanking must stay dark.
    do_reset();
    scan_and_check(1700);
  endtask

  task automatic test_mid_reset();
    fill_random();
    do_reset();
    scan_and_check(3 * 800 + 300);
    do_reset();
    @(negedge CLK_50);
    checks++;
    if (vga_hs !== 1'b1 || vga_vs !== 1'b1 || addr_screen !== 12'd0) begin
      errors++; $display("FAIL mid_reset_tick0 got hs=%b vs=%b addr=%0d want 1 1 0",
                         vga_hs, vga_vs, addr_screen);
    end
    @(negedge CLK_50);
    @(negedge CLK_50);
    checks++;
    if (addr_screen !== 12'd0) begin
      errors++; $display("FAIL mid_reset_first_fetch got %0d want 0", addr_screen);
    end
    @(negedge CLK_50);
    do_reset();
    scan_and_check(900);
  endtask

  task automatic test_back_to_back();
    fill_random();
    do_reset();
    do_reset();
    scan_and_check(200);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern_mode();
    fill_random();
    test_pattern = 1'b1;
    tp_mode      = 1'b1;
    do_reset();
    scan_and_check(1700);
    test_pattern = 1'b0;
    tp_mode      = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_scan_random();
    test_word0_blanking();
    test_mid_reset();
    test_back_to_back();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern_mode();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
